seq_right_shifter: RTL and testbench
====================================

SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits (N >= 2).
REQ-002 The block SHALL have derived constant SHW = clog2(N), meaning shift-amount width (5 for N=32).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 The block SHALL have port a  input  N  operand, captured on accepted start.
REQ-007 The block SHALL have port shamt  input  SHW  right-shift amount, 0..N-1, captured on accepted start.
REQ-008 The block SHALL have port arith  input  1  1 = arithmetic fill (sign bit), 0 = logical fill (zero), captured on accepted start.
REQ-009 The block SHALL have port busy  output  1  high whenever state != IDLE.
REQ-010 The block SHALL have port done  output  1  single-cycle pulse, high only in DONE.
REQ-011 The block SHALL have port result  output  N  shifted value; valid while done=1, held until the next accepted start.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1, the block SHALL accept on that clock edge: shreg<=a, cnt<=shamt, fill<=arith & a[N-1], and go to DONE if shamt==0, else to SHIFT.
REQ-014 In SHIFT, on each edge the block SHALL update shreg<={fill, shreg[N-1:1]} and cnt<=cnt-1, going to DONE on the edge where cnt==1.
REQ-015 In DONE, the block SHALL assert done=1 for exactly one cycle and go to IDLE unconditionally.
REQ-016 Latency: if start is accepted in cycle 0, done SHALL be high in cycle shamt+1 (1 cycle for shamt=0, N cycles for shamt=N-1).
REQ-017 The block SHALL ignore start while busy=1, including in DONE; captured operands SHALL NOT change.
REQ-018 result SHALL be driven directly from shreg; intermediate values visible during SHIFT are don't-care to consumers.
REQ-019 Arithmetic fill SHALL use the sign of the captured operand, never the sign of the current shreg.
REQ-020 Back-to-back: start held high SHALL be accepted again in the IDLE cycle that follows DONE, giving a minimum issue interval of shamt+2 cycles.

Reset
REQ-021 While rst_n=0, the block SHALL force the following immediately, without waiting for clk: state=IDLE, shreg=0, cnt=0, fill=0, busy=0, done=0, result=0.
REQ-022 Reset asserted mid-operation SHALL abort the shift with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-023 State encodings (IDLE=0, SHIFT=1, DONE=2) and the SHW computation SHALL live in shared package shift_pkg, reused by the ALU shift path.
REQ-024 The block SHALL instantiate one sub-module, shift_count_dn: a loadable SHW-bit down-counter with load, enable and a cnt_is_one flag.

Verification
REQ-025 The bench SHALL apply a=0x80000000, shamt=4, arith=0 and check done in cycle 5 with result=0x08000000.
REQ-026 The bench SHALL apply a=0x80000000, shamt=4, arith=1 and check done in cycle 5 with result=0xF8000000.
REQ-027 The bench SHALL apply a=0x12345678, shamt=0 and check done in cycle 1 with result=0x12345678.
REQ-028 The bench SHALL apply a=0x80000001, shamt=31, arith=1 and check done in cycle 32 with result=0xFFFFFFFF; with arith=0 it SHALL check result=0x00000001.
REQ-029 The bench SHALL start a=0xF0F0F0F0, shamt=8, then pulse start with a=0x0 at cycle 3 and check done in cycle 9 with result=0x00F0F0F0.
REQ-030 The bench SHALL drop rst_n at cycle 4 of a shamt=10 operation and check that busy and result go to 0 immediately, no done pulse occurs, and a subsequent start completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shift definitions: FSM state encoding and shift-amount width helper.
// Also used by the ALU shift path.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int shw_of(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/shift_count_dn.sv
// Loadable down-counter tracking the remaining shift steps.
// Flags the last step so the FSM can leave SHIFT on that edge.
module shift_count_dn #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_cnt_is_one
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt_is_one = (r_cnt == W'(1));

endmodule

// File: rtl/seq_right_shifter.sv
// Sequential right shifter: one bit per clock, logical or arithmetic fill.
// Fill bit is frozen at accept time from the captured operand's sign.
module seq_right_shifter
  import shift_pkg::*;
#(
  parameter  int N   = 32,
  localparam int SHW = shw_of(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] shamt,
  input  logic           arith,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);

  state_e       r_state;
  state_e       w_next;
  logic [N-1:0] r_shreg;
  logic         r_fill;
  logic         w_accept;
  logic         w_cnt_is_one;

  shift_count_dn #(.W(SHW)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_accept),
    .i_load_val   (shamt),
    .i_en         (r_state == S_SHIFT),
    .o_cnt_is_one (w_cnt_is_one)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: if (w_cnt_is_one) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shreg <= a;
        r_fill  <= arith & a[N-1];
      end else if (r_state == S_SHIFT) begin
        r_shreg <= {r_fill, r_shreg[N-1:1]};
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_shreg;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard bench for seq_right_shifter: expected result and done latency
// are queued at issue and popped when done is observed.
module tb_seq_right_shifter;

  localparam int N   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [SHW-1:0] shamt;
  logic           arith;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;

  typedef struct {
    logic [N-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  seq_right_shifter #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .arith  (arith),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input int sh, input logic ar);
    logic signed [N-1:0] sv;
    sv = v;
    if (ar) return sv >>> sh;
    return v >> sh;
  endfunction

  // Drive one start pulse; returns at #1 after the accepting edge (cycle 1).
  task automatic issue(input logic [N-1:0] va, input int sh, input logic ar);
    exp_t e;
    a = va; shamt = SHW'(sh); arith = ar; start = 1'b1;
    e.res = ref_shift(va, sh, ar);
    e.lat = sh + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles (sampled at negedge) until done, starting from cycle lat0.
  task automatic wait_done(input int lat0, output int lat, output bit tmo);
    lat = lat0;
    tmo = 1'b1;
    for (int k = 0; k < N + 8; k++) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; shamt = '0; arith = 1'b0;
    #1;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== '0)  begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_op(input string nm, input logic [N-1:0] va, input int sh, input logic ar);
    int lat; bit tmo; exp_t e;
    issue(va, sh, ar);
    total++;
    if (sh > 0 && busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b exp=1", nm, busy); end
    wait_done(0, lat, tmo);
    total++;
    if (tmo) begin
      bad++; $display("FAIL %s_timeout no done within budget", nm);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, e.lat); end
      total++;
      if (result !== e.res) begin bad++; $display("FAIL %s_result got=%h exp=%h", nm, result, e.res); end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL %s_pulse done=%b busy=%b exp=0/0", nm, done, busy);
      end
      total++;
      if (result !== e.res) begin bad++; $display("FAIL %s_hold got=%h exp=%h", nm, result, e.res); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat; bit tmo; exp_t e;
    issue(32'hF0F0_F0F0, 8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = '0; shamt = SHW'(3); arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat, tmo);
    total++;
    if (tmo) begin
      bad++; $display("FAIL ignore_timeout no done within budget");
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (lat !== 9) begin bad++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
      total++;
      if (result !== e.res) begin bad++; $display("FAIL ignore_result got=%h exp=%h", result, e.res); end
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_restart busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat; bit tmo; exp_t e;
    exp_t e2;
    a = 32'hA5A5_0000; shamt = SHW'(2); arith = 1'b1; start = 1'b1;
    e.res = ref_shift(32'hA5A5_0000, 2, 1'b1); e.lat = 3;
    sb.push_back(e);
    @(posedge clk); #1;
    wait_done(0, lat, tmo);
    total++;
    if (tmo) begin
      bad++; $display("FAIL b2b_first_timeout no done within budget");
      sb.delete(); start = 1'b0;
    end else begin
      e = sb.pop_front();
      if (lat !== 3 || result !== e.res) begin
        bad++; $display("FAIL b2b_first lat=%0d res=%h exp lat=3 res=%h", lat, result, e.res);
      end
      @(posedge clk); #1;
      a = 32'h0000_1234; arith = 1'b0;
      e2.res = ref_shift(32'h0000_1234, 2, 1'b0); e2.lat = 7;
      sb.push_back(e2);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(4, lat, tmo);
      total++;
      if (tmo) begin
        bad++; $display("FAIL b2b_second_timeout no done within budget");
        void'(sb.pop_front());
      end else begin
        e2 = sb.pop_front();
        if (lat !== e2.lat) begin bad++; $display("FAIL b2b_interval got=%0d exp=%0d", lat, e2.lat); end
        total++;
        if (result !== e2.res) begin bad++; $display("FAIL b2b_result got=%h exp=%h", result, e2.res); end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bit seen;
    issue(32'hDEAD_BEEF, 10, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (result !== '0)  begin bad++; $display("FAIL abort_result got=%h exp=0", result); end
    sb.delete();
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_no_done got=1 exp=0"); end
    @(posedge clk); #1;
    test_op("after_abort", 32'h8000_00F0, 5, 1'b1);
  endtask

  initial begin
    test_reset();
    test_op("lsr4",      32'h8000_0000, 4,  1'b0);
    test_op("asr4",      32'h8000_0000, 4,  1'b1);
    test_op("sh0",       32'h1234_5678, 0,  1'b0);
    test_op("asr31",     32'h8000_0001, 31, 1'b1);
    test_op("lsr31",     32'h8000_0001, 31, 1'b0);
    test_op("asr_pos",   32'h7000_0000, 3,  1'b1);
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] rv;
      rv = $urandom;
      test_op("rand", rv, int'($urandom_range(0, N - 1)), logic'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
